// File: rtl/tm1638_pkg.sv
// Shared command encodings and responder state type for the TM1638 serial link.
package tm1638_pkg;

    // Command class, taken from bits [7:6] of the first byte of a frame
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Bit positions inside a data command
    localparam int READ_BIT  = 1;
    localparam int FIXED_BIT = 2;

    // Number of key-scan bits shifted back on a read
    localparam int KEY_BITS = 32;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        WAIT_END
    } tm_state_e;

endpackage

// File: rtl/tm1638_sio_sync.sv
// Synchronizers for the asynchronous serial pins plus edge pulses on clk/stb.
module tm1638_sio_sync #(
    parameter int sync_stages = 2
) (
    input  logic clock,
    input  logic sio_clk,
    input  logic sio_stb,
    input  logic sio_data_in,
    output logic clk_rise,
    output logic clk_fall,
    output logic stb_rise,
    output logic stb_fall,
    output logic data_sync
);

    logic [sync_stages-1:0] clk_sync;
    logic [sync_stages-1:0] stb_sync;
    logic [sync_stages-1:0] dat_sync;
    logic                   clk_prev;
    logic                   stb_prev;

    // Plain flop chains; they carry no state worth resetting and the FSM
    // ignores edges while it is held in reset.
    always_ff @(posedge clock) begin
        clk_sync <= {clk_sync[sync_stages-2:0], sio_clk};
        stb_sync <= {stb_sync[sync_stages-2:0], sio_stb};
        dat_sync <= {dat_sync[sync_stages-2:0], sio_data_in};
        clk_prev <= clk_sync[sync_stages-1];
        stb_prev <= stb_sync[sync_stages-1];
    end

    assign clk_rise  =  clk_sync[sync_stages-1] & ~clk_prev;
    assign clk_fall  = ~clk_sync[sync_stages-1] &  clk_prev;
    assign stb_rise  =  stb_sync[sync_stages-1] & ~stb_prev;
    assign stb_fall  = ~stb_sync[sync_stages-1] &  stb_prev;
    assign data_sync =  dat_sync[sync_stages-1];

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 serial responder: decodes commands, holds display RAM, returns key bytes.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int sync_stages = 2,
    parameter int ram_bytes   = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         sio_clk,
    input  logic                         sio_stb,
    input  logic                         sio_data_in,
    output logic                         sio_data_out,
    output logic                         sio_data_out_en,
    input  logic [31:0]                  keys,
    input  logic [$clog2(ram_bytes)-1:0] ram_addr,
    output logic [7:0]                   ram_data,
    output logic                         display_on,
    output logic [2:0]                   brightness,
    output logic                         frame_error
);

    localparam int                addr_w    = $clog2(ram_bytes);
    localparam logic [addr_w-1:0] ADDR_LAST = addr_w'(ram_bytes - 1);

    logic clk_rise, clk_fall, stb_rise, stb_fall, din;

    tm1638_sio_sync #(.sync_stages(sync_stages)) u_sync (
        .clock       (clock),
        .sio_clk     (sio_clk),
        .sio_stb     (sio_stb),
        .sio_data_in (sio_data_in),
        .clk_rise    (clk_rise),
        .clk_fall    (clk_fall),
        .stb_rise    (stb_rise),
        .stb_fall    (stb_fall),
        .data_sync   (din)
    );

    tm_state_e          state;
    logic [2:0]         bit_cnt;
    logic [6:0]         shreg;       // first seven bits of the byte, LSB-first
    logic               fixed_mode;
    logic [addr_w-1:0]  addr;
    logic [31:0]        key_snap;
    logic [5:0]         rd_idx;      // saturates at 32: remaining bits read as 0
    logic [7:0]         ram [ram_bytes];
    logic [7:0]         byte_in;

    // Completed byte when the 8th rising edge arrives
    assign byte_in  = {din, shreg};
    assign ram_data = ram[ram_addr];

    // Frame FSM, display RAM and all registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shreg           <= '0;
            fixed_mode      <= 1'b0;
            addr            <= '0;
            key_snap        <= '0;
            rd_idx          <= '0;
            sio_data_out    <= 1'b0;
            sio_data_out_en <= 1'b0;
            display_on      <= 1'b0;
            brightness      <= '0;
            frame_error     <= 1'b0;
            for (int i = 0; i < ram_bytes; i++) ram[i] <= '0;
        end else begin
            frame_error <= 1'b0;
            if (stb_rise) begin
                // Frame end wins over a coincident 8th clock edge
                state           <= IDLE;
                bit_cnt         <= '0;
                sio_data_out    <= 1'b0;
                sio_data_out_en <= 1'b0;
                if (bit_cnt != 3'd0) frame_error <= 1'b1;
            end else if (stb_fall) begin
                state           <= CMD;
                bit_cnt         <= '0;
                sio_data_out_en <= 1'b0;
            end else if (state != IDLE) begin
                if (clk_fall && state == READ) begin
                    sio_data_out    <= rd_idx[5] ? 1'b0 : key_snap[rd_idx[4:0]];
                    sio_data_out_en <= 1'b1;
                    if (!rd_idx[5]) rd_idx <= rd_idx + 6'd1;
                end
                if (clk_rise) begin
                    shreg   <= {din, shreg[6:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            CMD: begin
                                case (byte_in[7:6])
                                    CMD_DATA: begin
                                        fixed_mode <= byte_in[FIXED_BIT];
                                        if (byte_in[READ_BIT]) begin
                                            state    <= READ;
                                            key_snap <= keys;
                                            rd_idx   <= '0;
                                        end else begin
                                            state <= WAIT_END;
                                        end
                                    end
                                    CMD_ADDR: begin
                                        addr  <= byte_in[addr_w-1:0];
                                        state <= WRITE;
                                    end
                                    CMD_DISP: begin
                                        display_on <= byte_in[3];
                                        brightness <= byte_in[2:0];
                                        state      <= WAIT_END;
                                    end
                                    default: begin
                                        frame_error <= 1'b1;
                                        state       <= WAIT_END;
                                    end
                                endcase
                            end
                            WRITE: begin
                                ram[addr] <= byte_in;
                                if (!fixed_mode)
                                    addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench: drives framed serial traffic and compares against a byte-level model.
module tb_tm1638_responder;

    localparam int SS = 2;
    localparam int H  = SS + 3;   // serial half period in system clocks

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sio_clk = 1'b1;
    logic        sio_stb = 1'b1;
    logic        sio_data_in = 1'b0;
    logic [31:0] keys = '0;
    logic [3:0]  ram_addr = '0;
    wire         sio_data_out, sio_data_out_en, display_on, frame_error;
    wire  [2:0]  brightness;
    wire  [7:0]  ram_data;

    tm1638_responder #(.sync_stages(SS), .ram_bytes(16)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .sio_clk         (sio_clk),
        .sio_stb         (sio_stb),
        .sio_data_in     (sio_data_in),
        .sio_data_out    (sio_data_out),
        .sio_data_out_en (sio_data_out_en),
        .keys            (keys),
        .ram_addr        (ram_addr),
        .ram_data        (ram_data),
        .display_on      (display_on),
        .brightness      (brightness),
        .frame_error     (frame_error)
    );

    always #5 clock = ~clock;

    int n_vec = 0, n_err = 0, fe_seen = 0;
    always @(negedge clock) if (frame_error) fe_seen++;

    // Reference model state
    logic [7:0] m_ram [16];
    bit         m_fixed;
    bit         m_on;
    logic [2:0] m_bri;
    int         m_fe;
    logic [3:0] m_addr;
    logic [7:0] fq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_fixed = 0; m_on = 0; m_bri = 3'd0; m_addr = 4'd0;
    endtask

    // Apply one write/control frame (bytes in fq, then `partial` stray bits)
    task automatic model_frame(input int partial);
        if (fq.size() > 0) begin
            case (fq[0][7:6])
                2'b01: m_fixed = fq[0][2];
                2'b10: begin m_on = fq[0][3]; m_bri = fq[0][2:0]; end
                2'b11: begin
                    m_addr = fq[0][3:0];
                    for (int i = 1; i < fq.size(); i++) begin
                        m_ram[m_addr] = fq[i];
                        if (!m_fixed) m_addr = 4'((int'(m_addr) + 1) % 16);
                    end
                end
                default: m_fe++;
            endcase
        end
        if (partial != 0) m_fe++;
    endtask

    task automatic send_bit(input bit b);
        sio_clk = 1'b0; sio_data_in = b; wait_clks(H);
        sio_clk = 1'b1; wait_clks(H);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic write_frame(input int partial);
        sio_stb = 1'b0; wait_clks(H);
        foreach (fq[i]) send_byte(fq[i]);
        for (int i = 0; i < partial; i++) send_bit(1'($urandom));
        sio_stb = 1'b1; wait_clks(H);
        model_frame(partial);
    endtask

    // Read frame: keys swap to new_keys after the command to prove the snapshot
    task automatic read_frame(input logic [7:0] cmd, input int nbits,
                              input logic [31:0] new_keys, input bit close);
        logic [31:0] snap;
        logic [7:0]  rx;
        bit          en_ok;
        sio_stb = 1'b0; wait_clks(H);
        send_byte(cmd);
        m_fixed = cmd[2];
        snap = keys;
        keys = new_keys;
        en_ok = 1; rx = '0;
        for (int b = 0; b < nbits; b++) begin
            sio_clk = 1'b0; wait_clks(H);
            if (sio_data_out_en !== 1'b1) en_ok = 0;
            rx[b % 8] = sio_data_out;
            sio_clk = 1'b1; wait_clks(H);
            if (b % 8 == 7)
                chk($sformatf("rd_byte%0d", b / 8), {24'd0, rx},
                    (b < 32) ? {24'd0, snap[8*(b/8) +: 8]} : 32'd0);
        end
        chk("rd_out_en", {31'd0, en_ok}, 32'd1);
        if (close) begin
            sio_stb = 1'b1; wait_clks(SS + 1);
            chk("out_en_after_stb", {31'd0, sio_data_out_en}, 32'd0);
            wait_clks(H);
        end
    endtask

    task automatic check_ram(input string tag);
        for (int a = 0; a < 16; a++) begin
            ram_addr = 4'(a); #1;
            chk($sformatf("%s_ram%0d", tag, a), {24'd0, ram_data}, {24'd0, m_ram[a]});
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_disp_on"}, {31'd0, display_on}, {31'd0, m_on});
        chk({tag, "_bright"}, {29'd0, brightness}, {29'd0, m_bri});
        chk({tag, "_fe_cnt"}, fe_seen, m_fe);
    endtask

    initial begin
        m_fe = 0;
        model_reset();
        wait_clks(6);
        chk("rst_out", {31'd0, sio_data_out}, 32'd0);
        chk("rst_out_en", {31'd0, sio_data_out_en}, 32'd0);
        chk("rst_fe", {31'd0, frame_error}, 32'd0);
        check_regs("rst");
        check_ram("rst");
        reset_n = 1'b1;
        wait_clks(H);

        // Auto-increment fill of the whole RAM
        fq = '{8'h40}; write_frame(0);
        fq = '{8'hC0};
        for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
        write_frame(0);
        check_ram("fill");
        check_regs("fill");

        // Fixed mode, then auto with wrap 15 -> 0
        fq = '{8'h44}; write_frame(0);
        fq = '{8'hC5, 8'hAA, 8'hBB}; write_frame(0);
        check_ram("fixed");
        fq = '{8'h40}; write_frame(0);
        fq = '{8'hCF, 8'h11, 8'h22}; write_frame(0);
        check_ram("wrap");

        // Display control
        fq = '{8'h8B}; write_frame(0); check_regs("disp8b");
        fq = '{8'h80}; write_frame(0); check_regs("disp80");

        // Key read
        keys = 32'h8040_2010;
        read_frame(8'h42, 32, $urandom, 1);
        check_regs("read");

        // Aborted data byte and illegal command
        fq = '{8'hC2}; write_frame(5);
        check_ram("abort");
        check_regs("abort");
        fq = '{8'h00}; write_frame(0);
        check_regs("cmd00");

        // Reads past 32 bits return 0 with out_en held
        keys = $urandom;
        read_frame(8'h42, 40, $urandom, 1);

        // Reset mid-read at bit 12
        keys = $urandom;
        read_frame(8'h42, 12, $urandom, 0);
        reset_n = 1'b0; wait_clks(1);
        chk("rst_mid_out_en", {31'd0, sio_data_out_en}, 32'd0);
        wait_clks(3);
        reset_n = 1'b1;
        model_reset();
        sio_stb = 1'b1; wait_clks(2 * H);
        check_ram("rst_mid");
        check_regs("rst_mid");
        keys = $urandom;
        read_frame(8'h42, 8, $urandom, 1);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            int kind, partial;
            kind = $urandom_range(0, 4);
            partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            fq = '{};
            case (kind)
                0: fq.push_back(8'h40 | (8'($urandom) & 8'h3D));
                1: begin
                    fq.push_back(8'hC0 | (8'($urandom) & 8'h3F));
                    for (int j = $urandom_range(1, 6); j > 0; j--) fq.push_back(8'($urandom));
                end
                2: fq.push_back(8'h80 | (8'($urandom) & 8'h3F));
                3: fq.push_back(8'($urandom) & 8'h3F);
                default: ;
            endcase
            if (kind == 4) begin
                keys = $urandom;
                read_frame(($urandom_range(0, 1) != 0) ? 8'h46 : 8'h42,
                           8 * $urandom_range(1, 5), $urandom, 1);
            end else begin
                if (kind != 1 && $urandom_range(0, 1) != 0) fq.push_back(8'($urandom));
                write_frame(partial);
            end
            check_regs($sformatf("rnd%0d", it));
            check_ram($sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
